// File: rtl/ram_arbiter.sv
// Shares one single-port sync RAM among NUM_PORTS requesters; grant is same-cycle, RAM strobes one cycle later, read data two.
// Backpressure: an ungranted requester holds its request; lock restricts eligibility to the owner while its lock_i stays high.
module ram_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ARB_MODE  = 0
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic [NUM_PORTS-1:0]        req_i,
   input  logic [NUM_PORTS-1:0]        we_i,
   input  logic [NUM_PORTS-1:0]        lock_i,
   input  logic [NUM_PORTS*ADDR_W-1:0] addr_i,
   input  logic [NUM_PORTS*DATA_W-1:0] wdata_i,
   output logic [NUM_PORTS-1:0]        gnt_o,
   output logic [NUM_PORTS-1:0]        rvalid_o,
   output logic [DATA_W-1:0]           rdata_o,
   output logic                        ram_en_o,
   output logic                        ram_we_o,
   output logic [ADDR_W-1:0]           ram_addr_o,
   output logic [DATA_W-1:0]           ram_data_o,
   input  logic [DATA_W-1:0]           ram_data_i
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef enum logic {IDLE, LOCKED} lock_state_t;

   lock_state_t          state;
   logic [IDX_W-1:0]     owner;
   logic [IDX_W-1:0]     last_gnt;
   logic [IDX_W-1:0]     win;
   logic                 win_vld;
   logic                 lock_hold;
   logic [NUM_PORTS-1:0] elig;
   int                   base;
   int                   p;
   logic                 rd1_vld;
   logic                 rd2_vld;
   logic [IDX_W-1:0]     rd1_tag;
   logic [IDX_W-1:0]     rd2_tag;

   // A lock only restricts eligibility in cycles where the owner still asserts lock_i.
   always_comb begin
      lock_hold = (state == LOCKED) && lock_i[owner];
      elig      = req_i;
      if (lock_hold) begin
         elig        = '0;
         elig[owner] = req_i[owner];
      end
   end

   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      p       = 0;
      base    = (ARB_MODE == 1) ? int'(last_gnt) + 1 : 0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         p = (base + i) % NUM_PORTS;
         if (!win_vld && elig[p]) begin
            win_vld = 1'b1;
            win     = IDX_W'(p);
         end
      end
      if (rst_i) win_vld = 1'b0;
   end

   always_comb begin
      gnt_o = '0;
      if (win_vld) gnt_o[win] = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state      <= IDLE;
         owner      <= '0;
         last_gnt   <= IDX_W'(NUM_PORTS - 1);
         ram_en_o   <= 1'b0;
         ram_we_o   <= 1'b0;
         ram_addr_o <= '0;
         ram_data_o <= '0;
         rd1_vld    <= 1'b0;
         rd1_tag    <= '0;
         rd2_vld    <= 1'b0;
         rd2_tag    <= '0;
      end else begin
         ram_en_o <= win_vld;
         ram_we_o <= win_vld && we_i[win];
         rd1_vld  <= win_vld && !we_i[win];
         rd1_tag  <= win;
         rd2_vld  <= rd1_vld;
         rd2_tag  <= rd1_tag;
         if (win_vld) begin
            last_gnt   <= win;
            ram_addr_o <= addr_i[int'(win)*ADDR_W +: ADDR_W];
            ram_data_o <= wdata_i[int'(win)*DATA_W +: DATA_W];
         end
         // A locking winner takes ownership even if a stale lock is being released this cycle.
         if (win_vld && lock_i[win]) begin
            state <= LOCKED;
            owner <= win;
         end else if (!lock_hold) begin
            state <= IDLE;
         end
      end
   end

   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      if (rd2_vld) begin
         rvalid_o[rd2_tag] = 1'b1;
         rdata_o           = ram_data_i;
      end
   end

endmodule

// File: tb/tb_ram_arbiter.sv
// Drives a fixed-priority and a round-robin arbiter with identical stimulus, each with its own RAM,
// and compares both against a transaction-level model of grants, RAM strobes and returned reads.
module tb_ram_arbiter;
   localparam int N = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           clr;
   logic [N-1:0]   req, we, lock;
   logic [N*32-1:0] addr, wdata;

   logic [N-1:0]   gnt [2];
   logic [N-1:0]   rv [2];
   logic [31:0]    rd [2];
   logic           ram_en [2];
   logic           ram_we [2];
   logic [31:0]    ram_addr [2];
   logic [31:0]    ram_wd [2];
   logic [31:0]    ram_q [2];
   logic [31:0]    mem [2][256];

   ram_arbiter #(.NUM_PORTS(N), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0)) u_fp (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rv[0]), .rdata_o(rd[0]),
      .ram_en_o(ram_en[0]), .ram_we_o(ram_we[0]), .ram_addr_o(ram_addr[0]),
      .ram_data_o(ram_wd[0]), .ram_data_i(ram_q[0]));

   ram_arbiter #(.NUM_PORTS(N), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1)) u_rr (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .lock_i(lock),
      .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rv[1]), .rdata_o(rd[1]),
      .ram_en_o(ram_en[1]), .ram_we_o(ram_we[1]), .ram_addr_o(ram_addr[1]),
      .ram_data_o(ram_wd[1]), .ram_data_i(ram_q[1]));

   // Single-port synchronous RAM per arbiter
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (clr) begin
            for (int a = 0; a < 256; a++) mem[m][a] <= '0;
            ram_q[m] <= '0;
         end else if (ram_en[m]) begin
            if (ram_we[m]) mem[m][ram_addr[m][7:0]] <= ram_wd[m];
            else           ram_q[m] <= mem[m][ram_addr[m][7:0]];
         end
      end
   end

   // Reference model: accesses are applied to memory in grant order; reads are due two cycles later.
   typedef struct {
      int          m;
      int          due;
      int          port;
      logic [31:0] dat;
   } rd_t;

   rd_t         pend[$];
   logic [31:0] mm [2][256];
   int          lk [2];
   int          own [2];
   int          last [2];
   logic        xen [2];
   logic        xwe [2];
   logic [31:0] xaddr [2];
   logic [31:0] xdat [2];
   int          cyc;
   int          checks;
   int          errors;

   logic [N-1:0] s_gnt [2];
   logic [N-1:0] s_rv [2];
   logic         s_en [2];
   logic [31:0]  s_rd [2];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input int m);
      if (lk[m] != 0 && lock[own[m]]) return req[own[m]] ? own[m] : -1;
      for (int i = 0; i < N; i++) begin
         int q;
         q = (m == 1) ? (last[m] + 1 + i) % N : i;
         if (req[q]) return q;
      end
      return -1;
   endfunction

   task automatic model_reset(input int m);
      lk[m]    = 0;
      own[m]   = 0;
      last[m]  = N - 1;
      xen[m]   = 1'b0;
      xwe[m]   = 1'b0;
      xaddr[m] = '0;
      xdat[m]  = '0;
   endtask

   task automatic set_port(input int k, input logic [31:0] a, input logic [31:0] d);
      addr[k*32 +: 32]  = a;
      wdata[k*32 +: 32] = d;
   endtask

   task automatic step();
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
         int           w;
         logic [N-1:0] eg;
         logic [N-1:0] erv;
         logic [31:0]  erd;
         bit           has;
         logic [31:0]  a;
         w = rst ? -1 : pick(m);
         eg = '0;
         if (w >= 0) eg[w] = 1'b1;
         s_gnt[m] = gnt[m];
         s_rv[m]  = rv[m];
         s_en[m]  = ram_en[m];
         s_rd[m]  = rd[m];
         chk($sformatf("gnt_m%0d", m), 32'(gnt[m]), 32'(eg));
         chk($sformatf("ram_en_m%0d", m), 32'(ram_en[m]), 32'(xen[m]));
         chk($sformatf("ram_we_m%0d", m), 32'(ram_we[m]), 32'(xwe[m]));
         chk($sformatf("ram_addr_m%0d", m), ram_addr[m], xaddr[m]);
         chk($sformatf("ram_data_m%0d", m), ram_wd[m], xdat[m]);
         erv = '0;
         erd = '0;
         has = 1'b0;
         foreach (pend[i]) begin
            if (pend[i].m == m && pend[i].due == cyc) begin
               erv[pend[i].port] = 1'b1;
               erd = pend[i].dat;
               has = 1'b1;
            end
         end
         chk($sformatf("rvalid_m%0d", m), 32'(rv[m]), 32'(erv));
         if (has) chk($sformatf("rdata_m%0d", m), rd[m], erd);
         if (rst) begin
            model_reset(m);
         end else begin
            xen[m] = (w >= 0);
            xwe[m] = 1'b0;
            if (w >= 0) begin
               a        = addr[w*32 +: 32];
               xwe[m]   = we[w];
               xaddr[m] = a;
               xdat[m]  = wdata[w*32 +: 32];
               last[m]  = w;
               if (we[w]) mm[m][a[7:0]] = xdat[m];
               else pend.push_back('{m, cyc + 2, w, mm[m][a[7:0]]});
               if (lock[w]) begin
                  lk[m]  = 1;
                  own[m] = w;
               end else begin
                  lk[m] = 0;
               end
            end else if (lk[m] != 0 && !lock[own[m]]) begin
               lk[m] = 0;
            end
         end
      end
      if (rst) pend.delete();
      while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      rst    = 1'b1;
      clr    = 1'b1;
      req    = '1;
      we     = '0;
      lock   = '0;
      addr   = '0;
      wdata  = '0;
      for (int m = 0; m < 2; m++) begin
         model_reset(m);
         for (int a = 0; a < 256; a++) mm[m][a] = '0;
      end

      // Reset held with every port requesting
      repeat (3) begin
         step();
         chk("rst_gnt", 32'(s_gnt[0] | s_gnt[1]), 32'h0);
         chk("rst_en", 32'(s_en[0] | s_en[1]), 32'h0);
         chk("rst_rvalid", 32'(s_rv[0] | s_rv[1]), 32'h0);
      end
      clr = 1'b0;
      rst = 1'b0;
      step();
      chk("first_gnt_fp", 32'(s_gnt[0]), 32'h1);
      chk("first_gnt_rr", 32'(s_gnt[1]), 32'h1);
      req = '0;
      repeat (2) step();

      // Fixed priority: write via port 2, then ports 0 and 1 read the same word
      req = 3'b100; we = 3'b100; set_port(2, 32'h10, 32'hA5A5_0001);
      step();
      chk("fp_wr_gnt", 32'(s_gnt[0]), 32'h4);
      req = 3'b011; we = 3'b000; set_port(0, 32'h10, 32'h0); set_port(1, 32'h10, 32'h0);
      step();
      chk("fp_rd_gnt0", 32'(s_gnt[0]), 32'h1);
      req = 3'b010;
      step();
      chk("fp_rd_gnt1", 32'(s_gnt[0]), 32'h2);
      req = 3'b000;
      step();
      chk("fp_rv0", 32'(s_rv[0]), 32'h1);
      chk("fp_rd0", s_rd[0], 32'hA5A5_0001);
      step();
      chk("fp_rv1", 32'(s_rv[0]), 32'h2);
      chk("fp_rd1", s_rd[0], 32'hA5A5_0001);

      // Round-robin rotation from a pointer parked on port 2
      req = 3'b100;
      step();
      req = 3'b111;
      for (int i = 0; i < 6; i++) begin
         step();
         chk($sformatf("rr_seq%0d", i), 32'(s_gnt[1]), 32'(1 << (i % 3)));
         chk($sformatf("fp_hold%0d", i), 32'(s_gnt[0]), 32'h1);
      end
      req = '0;
      repeat (2) step();

      // Lock: port 1 owns the bus while port 0 waits
      req = 3'b010; lock = 3'b010;
      step();
      chk("lock_take", 32'(s_gnt[0]), 32'h2);
      req = 3'b011;
      repeat (2) begin
         step();
         chk("lock_fp", 32'(s_gnt[0]), 32'h2);
         chk("lock_rr", 32'(s_gnt[1]), 32'h2);
      end
      req = 3'b001;
      step();
      chk("lock_bubble", 32'(s_gnt[0] | s_gnt[1]), 32'h0);
      req = 3'b011;
      step();
      chk("bubble_en", 32'(s_en[0] | s_en[1]), 32'h0);
      chk("lock_last", 32'(s_gnt[0]), 32'h2);
      lock = 3'b000;
      step();
      chk("unlock_fp", 32'(s_gnt[0]), 32'h1);
      chk("unlock_rr", 32'(s_gnt[1]), 32'h1);
      req = '0;
      repeat (3) step();

      // Reset arriving the cycle after a read grant
      req = 3'b100; set_port(2, 32'h10, 32'h0);
      step();
      chk("mid_gnt", 32'(s_gnt[0]), 32'h4);
      req = '0; rst = 1'b1;
      step();
      rst = 1'b0;
      repeat (2) begin
         step();
         chk("mid_rvalid", 32'(s_rv[0] | s_rv[1]), 32'h0);
      end

      // Write then read of the same word on consecutive grants
      req = 3'b001; we = 3'b001; set_port(0, 32'h4, 32'h1234);
      step();
      chk("wr_gnt", 32'(s_gnt[0]), 32'h1);
      req = 3'b010; we = 3'b000; set_port(1, 32'h4, 32'h0);
      step();
      chk("rd_gnt", 32'(s_gnt[0]), 32'h2);
      req = '0;
      repeat (2) step();
      chk("wr_rd_rv_fp", 32'(s_rv[0]), 32'h2);
      chk("wr_rd_data_fp", s_rd[0], 32'h1234);
      chk("wr_rd_rv_rr", 32'(s_rv[1]), 32'h2);
      chk("wr_rd_data_rr", s_rd[1], 32'h1234);

      // Random traffic with occasional locks and resets
      for (int i = 0; i < 800; i++) begin
         rst  = ($urandom_range(0, 63) == 0);
         req  = N'($urandom);
         we   = N'($urandom);
         lock = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
         for (int k = 0; k < N; k++) set_port(k, 32'($urandom_range(0, 31)), $urandom);
         step();
      end
      rst = 1'b0;
      req = '0;
      lock = '0;
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
